// File: rtl/clahe_tdp_ram.sv
// clahe_tdp_ram: parametrised true dual-port RAM with write modes, collision handling and a clear engine
module clahe_tdp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter string WRITE_MODE_A = "READ_FIRST",
  parameter string WRITE_MODE_B = "READ_FIRST",
  parameter bit OUTPUT_REG = 1'b0,
  parameter string COLL_PRIORITY = "A",
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              coll_flag,
  output logic [15:0]       coll_cnt
);
  localparam bit OK_A = WRITE_MODE_A == "READ_FIRST" || WRITE_MODE_A == "WRITE_FIRST" || WRITE_MODE_A == "NO_CHANGE";
  localparam bit OK_B = WRITE_MODE_B == "READ_FIRST" || WRITE_MODE_B == "WRITE_FIRST" || WRITE_MODE_B == "NO_CHANGE";
  localparam bit OK_P = COLL_PRIORITY == "A" || COLL_PRIORITY == "B";
  localparam bit WF_A = WRITE_MODE_A == "WRITE_FIRST";
  localparam bit NC_A = WRITE_MODE_A == "NO_CHANGE";
  localparam bit WF_B = WRITE_MODE_B == "WRITE_FIRST";
  localparam bit NC_B = WRITE_MODE_B == "NO_CHANGE";
  localparam bit PRI_A = COLL_PRIORITY == "A";
  if (!(OK_A && OK_B && OK_P && DATA_W >= 1 && DATA_W <= 32)) begin : g_bad
    $fatal(1, "ERROR: clahe_tdp_ram illegal parameter set");
  end
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] a_q, b_q;
  logic a_v, b_v, a_acc, b_acc, a_wr, b_wr, coll;
  always_comb begin
    a_acc = a_en && state == IDLE && !rst;
    b_acc = b_en && state == IDLE && !rst;
    a_wr = a_acc && a_we;
    b_wr = b_acc && b_we;
    coll = a_wr && b_wr && a_addr == b_addr;
  end
  assign clr_busy = state == CLEAR;
  // the array has no reset; a colliding write from the losing port is dropped
  always_ff @(posedge clk) begin
    if (!rst && state == CLEAR) mem[cnt] <= CLEAR_VALUE;
    if (a_wr && !(coll && !PRI_A)) mem[a_addr] <= a_wdata;
    if (b_wr && !(coll && PRI_A)) mem[b_addr] <= b_wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      a_v <= 1'b0;
      b_v <= 1'b0;
    end else begin
      a_v <= a_acc && !a_we;
      b_v <= b_acc && !b_we;
      if (a_acc && !(a_we && NC_A)) a_q <= a_we && WF_A ? a_wdata : mem[a_addr];
      if (b_acc && !(b_we && NC_B)) b_q <= b_we && WF_B ? b_wdata : mem[b_addr];
    end
  end
  if (OUTPUT_REG) begin : g_oreg
    always_ff @(posedge clk) begin
      if (rst) begin
        a_rdata <= '0;
        b_rdata <= '0;
        a_rvalid <= 1'b0;
        b_rvalid <= 1'b0;
      end else begin
        a_rdata <= a_q;
        b_rdata <= b_q;
        a_rvalid <= a_v;
        b_rvalid <= b_v;
      end
    end
  end else begin : g_direct
    always_comb begin
      a_rdata = a_q;
      b_rdata = b_q;
      a_rvalid = a_v;
      b_rvalid = b_v;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? CLEAR : IDLE;
      cnt <= '0;
      coll_flag <= 1'b0;
      coll_cnt <= '0;
    end else begin
      coll_flag <= coll;
      if (coll && coll_cnt != 16'hFFFF) coll_cnt <= coll_cnt + 16'd1;
      if (state == IDLE && clr_req) begin
        state <= CLEAR;
        cnt <= '0;
      end else if (state == CLEAR) begin
        cnt <= cnt + 1'b1;
        if (&cnt) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_clahe_tdp_ram.sv
// tb_clahe_tdp_ram: scoreboard bench driving two differently configured RAMs from shared random stimulus
module tb_clahe_tdp_ram;
  logic clk = 1'b0;
  logic rst, clr_req, a_en, a_we, b_en, b_we;
  logic [3:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic [15:0] ard [2], brd [2], cc [2];
  logic arv [2], brv [2], busy [2], cf [2];
  int tests = 0, fails = 0;
  bit done = 0;

  always #5 clk = ~clk;

  clahe_tdp_ram #(.DATA_W(16), .ADDR_W(4), .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("NO_CHANGE"),
    .OUTPUT_REG(1'b0), .COLL_PRIORITY("B"), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(16'h0000)) u0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(busy[0]),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(ard[0]), .a_rvalid(arv[0]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(brd[0]), .b_rvalid(brv[0]),
    .coll_flag(cf[0]), .coll_cnt(cc[0]));

  clahe_tdp_ram #(.DATA_W(16), .ADDR_W(4), .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("READ_FIRST"),
    .OUTPUT_REG(1'b1), .COLL_PRIORITY("A"), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(16'h00A5)) u1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(busy[1]),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(ard[1]), .a_rvalid(arv[1]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(brd[1]), .b_rvalid(brv[1]),
    .coll_flag(cf[1]), .coll_cnt(cc[1]));

  typedef struct packed {logic v; logic [15:0] d;} port_t;
  typedef struct packed {logic busy; logic flag; logic [15:0] cnt;} stat_t;
  port_t qa0[$], qb0[$], qa1[$], qb1[$];
  stat_t qs0[$], qs1[$];

  // reference model: 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE
  int mode_a [2] = '{1, 0};
  int mode_b [2] = '{2, 0};
  bit pri_b [2] = '{1, 0};
  bit oreg [2] = '{0, 1};
  logic [15:0] cv [2] = '{16'h0000, 16'h00A5};
  logic [15:0] mm [2][16];
  bit mbusy [2];
  int mcnt [2], mcc [2];
  logic [15:0] pa [2], pb [2];

  function automatic port_t resp(int mode, logic en, logic we, logic [3:0] addr, logic [15:0] wd,
                                 logic [15:0] old [16], logic [15:0] prev);
    if (!en) return '{1'b0, prev};
    if (!we) return '{1'b1, old[addr]};
    if (mode == 0) return '{1'b0, old[addr]};
    if (mode == 1) return '{1'b0, wd};
    return '{1'b0, prev};
  endfunction

  task automatic model(int d);
    port_t ea, eb;
    stat_t es;
    logic [15:0] old [16];
    bit fl = 0;
    old = mm[d];
    if (rst) begin
      mbusy[d] = 1;
      mcnt[d] = 0;
      mcc[d] = 0;
      ea = '0;
      eb = '0;
      if (oreg[d]) begin
        qa1[qa1.size()-1] = '0;
        qb1[qb1.size()-1] = '0;
      end
    end else if (mbusy[d]) begin
      mm[d][mcnt[d]] = cv[d];
      mcnt[d]++;
      if (mcnt[d] == 16) mbusy[d] = 0;
      ea = '{1'b0, pa[d]};
      eb = '{1'b0, pb[d]};
    end else begin
      ea = resp(mode_a[d], a_en, a_we, a_addr, a_wdata, old, pa[d]);
      eb = resp(mode_b[d], b_en, b_we, b_addr, b_wdata, old, pb[d]);
      if (a_en && a_we && b_en && b_we && a_addr == b_addr) begin
        fl = 1;
        if (mcc[d] < 65535) mcc[d]++;
        mm[d][a_addr] = pri_b[d] ? b_wdata : a_wdata;
      end else begin
        if (a_en && a_we) mm[d][a_addr] = a_wdata;
        if (b_en && b_we) mm[d][b_addr] = b_wdata;
      end
      if (clr_req) begin
        mbusy[d] = 1;
        mcnt[d] = 0;
      end
    end
    pa[d] = ea.d;
    pb[d] = eb.d;
    es = '{mbusy[d], fl, 16'(mcc[d])};
    if (d == 0) begin
      qa0.push_back(ea);
      qb0.push_back(eb);
      qs0.push_back(es);
    end else begin
      qa1.push_back(ea);
      qb1.push_back(eb);
      qs1.push_back(es);
    end
  endtask

  task automatic put(bit r, bit c, bit ae, bit awe, int aa, int awd, bit be, bit bwe, int ba, int bwd);
    rst = r;
    clr_req = c;
    a_en = ae;
    a_we = awe;
    a_addr = 4'(aa);
    a_wdata = 16'(awd);
    b_en = be;
    b_we = bwe;
    b_addr = 4'(ba);
    b_wdata = 16'(bwd);
    model(0);
    model(1);
  endtask

  task automatic cyc(bit r, bit c, bit ae, bit awe, int aa, int awd, bit be, bit bwe, int ba, int bwd);
    @(negedge clk);
    put(r, c, ae, awe, aa, awd, be, bwe, ba, bwd);
  endtask

  task automatic rnd(int clr_odds);
    cyc(0, $urandom_range(clr_odds - 1) == 0, $urandom_range(9) < 7, $urandom_range(1), $urandom, $urandom,
        $urandom_range(9) < 7, $urandom_range(1), $urandom, $urandom);
  endtask

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
    end
  endtask

  task automatic mon(int d);
    port_t ea, eb;
    stat_t es;
    if ((d == 0 ? qs0.size() : qs1.size()) == 0 || (d == 0 ? qa0.size() : qa1.size()) == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    es = d == 0 ? qs0.pop_front() : qs1.pop_front();
    ea = d == 0 ? qa0.pop_front() : qa1.pop_front();
    eb = d == 0 ? qb0.pop_front() : qb1.pop_front();
    chk($sformatf("clr_busy%0d", d), 32'(busy[d]), 32'(es.busy));
    chk($sformatf("coll_flag%0d", d), 32'(cf[d]), 32'(es.flag));
    chk($sformatf("coll_cnt%0d", d), 32'(cc[d]), 32'(es.cnt));
    chk($sformatf("a_rvalid%0d", d), 32'(arv[d]), 32'(ea.v));
    chk($sformatf("a_rdata%0d", d), 32'(ard[d]), 32'(ea.d));
    chk($sformatf("b_rvalid%0d", d), 32'(brv[d]), 32'(eb.v));
    chk($sformatf("b_rdata%0d", d), 32'(brd[d]), 32'(eb.d));
  endtask

  initial begin
    @(posedge clk);
    while (!done) begin
      #1;
      mon(0);
      mon(1);
      @(posedge clk);
    end
  end

  initial begin
    qa1.push_back('0);
    qb1.push_back('0);
    put(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (18) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, i, 0, 1, 0, 15 - i, 0);
    cyc(0, 0, 1, 1, 3, 'h1234, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 3, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 3, 'hBEEF);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 3, 0, 1, 0, 3, 0);
    cyc(0, 0, 1, 1, 7, 'h1111, 1, 1, 7, 'h2222);
    cyc(0, 0, 1, 0, 7, 0, 1, 0, 7, 0);
    cyc(0, 0, 1, 1, 5, 'hAAAA, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 5, 0, 1, 1, 5, 'h5555);
    cyc(0, 0, 1, 0, 5, 0, 1, 0, 5, 0);
    cyc(0, 0, 1, 1, 6, 'h6666, 1, 0, 6, 0);
    cyc(0, 0, 1, 0, 6, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 1, i, 'hFFFF, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 9, 0, 0, 0, 0, 0);
    repeat (17) rnd(4);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, i, 0, 1, 0, (i + 5) % 16, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (6) rnd(1000000);
    cyc(1, 0, 1, 1, 2, 'h7777, 1, 1, 2, 'h8888);
    repeat (20) rnd(1000000);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, i, 0, 1, 0, 15 - i, 0);
    repeat (3000) rnd(150);
    @(negedge clk);
    done = 1;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
